sound_scheduler: RTL and testbench

Shares the single tone generator between all game sound requesters: the game-state controller (level-up, crash, celebration) and the menu/d-pad logic (UI press). Latches one-cycle request pulses, grants the tone generator by fixed priority, holds each sound for a per-sound duration counted in `tick` enables, and inserts a silent gap between sounds. Drives `soundselector`/`playsound` to the tone generator; higher-priority sounds preempt lower ones.

---
 rtl/sound_scheduler.sv | 161 ++++++++++++++++
 tb/tb_sound_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sound_scheduler.sv
// sound_scheduler: arbitrates the single tone generator between sound requesters.
// Latches one-cycle request pulses, grants by fixed priority
// (CRASH > CELEBRATION > NEXTLEVEL > UI_PRESS), plays each sound for a
// per-sound number of ticks, then holds a silent gap before the next one.
// A strictly higher-priority request preempts the sound currently playing.
// Ports:
//   clk               system clock
//   reset             synchronous, active-high reset
//   i_tick            timebase enable, one-cycle pulse
//   i_req[3:0]        request pulses (0 UI, 1 LEVEL, 2 CRASH, 3 CELEB)
//   o_soundselector   id of the sound currently (or last) granted
//   o_playsound       high while a sound is playing
//   o_busy            high in PLAY or GAP
//   o_pending[3:0]    latched, not-yet-granted requests
module sound_scheduler #(
  parameter int unsigned DUR_UI    = 4,
  parameter int unsigned DUR_LEVEL = 20,
  parameter int unsigned DUR_CRASH = 40,
  parameter int unsigned DUR_CELEB = 60,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick,
  input  logic [3:0] i_req,
  output logic [1:0] o_soundselector,
  output logic       o_playsound,
  output logic       o_busy,
  output logic [3:0] o_pending
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] C_DUR_UI    = CNT_W'(DUR_UI);
  localparam logic [CNT_W-1:0] C_DUR_LEVEL = CNT_W'(DUR_LEVEL);
  localparam logic [CNT_W-1:0] C_DUR_CRASH = CNT_W'(DUR_CRASH);
  localparam logic [CNT_W-1:0] C_DUR_CELEB = CNT_W'(DUR_CELEB);
  localparam logic [CNT_W-1:0] C_GAP       = CNT_W'(GAP_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           r_state,   w_state_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic [1:0]       r_sel,     w_sel_nxt;
  logic             r_play,    w_play_nxt;
  logic             r_busy,    w_busy_nxt;
  logic [3:0]       r_pending, w_pending_nxt;

  logic [1:0]       w_gnt_id;
  logic             w_has_req;
  logic             w_preempt;
  logic             w_grant;
  logic [3:0]       w_grant_mask;
  logic [CNT_W-1:0] w_gnt_dur;

  // Priority rank of a sound id; larger wins.
  function automatic logic [1:0] rank(input logic [1:0] id);
    case (id)
      2'd2:    rank = 2'd3;
      2'd3:    rank = 2'd2;
      2'd1:    rank = 2'd1;
      default: rank = 2'd0;
    endcase
  endfunction

  // Highest-priority pending id and its duration.
  always_comb begin
    w_has_req = |r_pending;
    if (r_pending[2])      w_gnt_id = 2'd2;
    else if (r_pending[3]) w_gnt_id = 2'd3;
    else if (r_pending[1]) w_gnt_id = 2'd1;
    else                   w_gnt_id = 2'd0;
    case (w_gnt_id)
      2'd0:    w_gnt_dur = C_DUR_UI;
      2'd1:    w_gnt_dur = C_DUR_LEVEL;
      2'd2:    w_gnt_dur = C_DUR_CRASH;
      default: w_gnt_dur = C_DUR_CELEB;
    endcase
    w_preempt = w_has_req && (rank(w_gnt_id) > rank(r_sel));
  end

  // Next-state and output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_play_nxt  = r_play;
    w_grant     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_play_nxt = 1'b0;
        if (w_has_req) w_grant = 1'b1;
      end
      ST_PLAY: begin
        if (w_preempt) begin
          w_grant = 1'b1;
        end else if (i_tick) begin
          if (r_cnt == CNT_W'(1)) begin
            w_play_nxt = 1'b0;
            w_cnt_nxt  = C_GAP;
            w_state_nxt = (C_GAP == '0) ? ST_IDLE : ST_GAP;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end
      ST_GAP: begin
        w_play_nxt = 1'b0;
        if (i_tick) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_play_nxt  = 1'b0;
      end
    endcase

    if (w_grant) begin
      w_state_nxt = ST_PLAY;
      w_sel_nxt   = w_gnt_id;
      w_play_nxt  = 1'b1;
      w_cnt_nxt   = w_gnt_dur;
    end

    // A request for the id being granted this cycle merges into the grant.
    w_grant_mask  = w_grant ? (4'b0001 << w_gnt_id) : 4'b0000;
    w_pending_nxt = (r_pending | i_req) & ~w_grant_mask;
    w_busy_nxt    = (w_state_nxt != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_sel     <= 2'd0;
      r_play    <= 1'b0;
      r_busy    <= 1'b0;
      r_pending <= 4'b0000;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sel     <= w_sel_nxt;
      r_play    <= w_play_nxt;
      r_busy    <= w_busy_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  assign o_soundselector = r_sel;
  assign o_playsound     = r_play;
  assign o_busy          = r_busy;
  assign o_pending       = r_pending;

endmodule

// File: tb/tb_sound_scheduler.sv
// Directed bench for sound_scheduler: default timing instance plus a
// zero-gap instance sharing clock, tick and reset.
module tb_sound_scheduler;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [3:0] req;
  logic [3:0] req_b;

  logic [1:0] sel_a, sel_b;
  logic       play_a, play_b;
  logic       busy_a, busy_b;
  logic [3:0] pend_a, pend_b;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  sound_scheduler #(
    .DUR_UI(4), .DUR_LEVEL(20), .DUR_CRASH(40), .DUR_CELEB(60), .GAP_TICKS(2)
  ) u_dut (
    .clk(clk), .reset(reset), .i_tick(tick), .i_req(req),
    .o_soundselector(sel_a), .o_playsound(play_a), .o_busy(busy_a), .o_pending(pend_a)
  );

  sound_scheduler #(
    .DUR_UI(4), .DUR_LEVEL(3), .DUR_CRASH(5), .DUR_CELEB(6), .GAP_TICKS(0)
  ) u_dut_nogap (
    .clk(clk), .reset(reset), .i_tick(tick), .i_req(req_b),
    .o_soundselector(sel_b), .o_playsound(play_b), .o_busy(busy_b), .o_pending(pend_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    n_total++;
    assert (obs === want) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  // Apply inputs for one clock edge; outputs are then read 1 time unit after it.
  task automatic step(input logic t, input logic [3:0] r, input logic [3:0] rb, input logic rs);
    tick  = t;
    req   = r;
    req_b = rb;
    reset = rs;
    @(posedge clk);
    #1;
    tick  = 1'b0;
    req   = 4'b0000;
    req_b = 4'b0000;
  endtask

  // k tick pulses, one every 10 cycles; the last step is the k-th tick edge.
  task automatic play_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      repeat (9) step(1'b0, 4'b0000, 4'b0000, 1'b0);
      step(1'b1, 4'b0000, 4'b0000, 1'b0);
    end
  endtask

  initial begin
    tick = 1'b0; req = 4'b0000; req_b = 4'b0000; reset = 1'b1;

    // Reset values; tick and req ignored while in reset
    step(1'b1, 4'b1111, 4'b1111, 1'b1);
    step(1'b0, 4'b0000, 4'b0000, 1'b1);
    chk("rst_play", 16'(play_a), 16'h0);
    chk("rst_sel",  16'(sel_a),  16'h0);
    chk("rst_busy", 16'(busy_a), 16'h0);
    chk("rst_pend", 16'(pend_a), 16'h0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Single UI press
    step(1'b0, 4'b0001, 4'b0000, 1'b0);
    chk("ui_pend",   16'(pend_a), 16'h1);
    chk("ui_play0",  16'(play_a), 16'h0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("ui_play1",  16'(play_a), 16'h1);
    chk("ui_sel",    16'(sel_a),  16'h0);
    chk("ui_pclr",   16'(pend_a), 16'h0);
    play_ticks(3);
    chk("ui_t3",     16'(play_a), 16'h1);
    play_ticks(1);
    chk("ui_t4",     16'(play_a), 16'h0);
    chk("ui_gbusy",  16'(busy_a), 16'h1);
    play_ticks(1);
    chk("ui_g1",     16'(busy_a), 16'h1);
    play_ticks(1);
    chk("ui_g2",     16'(busy_a), 16'h0);

    // Two simultaneous requests: CELEBRATION then NEXTLEVEL
    step(1'b0, 4'b1010, 4'b0000, 1'b0);
    chk("two_pend",  16'(pend_a), 16'ha);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("two_sel3",  16'(sel_a),  16'h3);
    chk("two_pend2", 16'(pend_a), 16'h2);
    play_ticks(59);
    chk("two_t59",   16'(play_a), 16'h1);
    play_ticks(1);
    chk("two_t60",   16'(play_a), 16'h0);
    play_ticks(2);
    chk("two_gidle", 16'(play_a), 16'h0);
    chk("two_gbusy", 16'(busy_a), 16'h0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("two_sel1",  16'(sel_a),  16'h1);
    chk("two_play",  16'(play_a), 16'h1);
    play_ticks(19);
    chk("lvl_t19",   16'(play_a), 16'h1);
    play_ticks(1);
    chk("lvl_t20",   16'(play_a), 16'h0);
    play_ticks(2);
    chk("lvl_idle",  16'(busy_a), 16'h0);

    // CRASH preempts CELEBRATION
    step(1'b0, 4'b1000, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("pre_sel3",  16'(sel_a),  16'h3);
    play_ticks(5);
    step(1'b0, 4'b0100, 4'b0000, 1'b0);
    chk("pre_n1sel", 16'(sel_a),  16'h3);
    chk("pre_n1pl",  16'(play_a), 16'h1);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("pre_sel2",  16'(sel_a),  16'h2);
    chk("pre_n2pl",  16'(play_a), 16'h1);
    play_ticks(39);
    chk("cr_t39",    16'(play_a), 16'h1);
    play_ticks(1);
    chk("cr_t40",    16'(play_a), 16'h0);
    play_ticks(2);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("cr_noresm", 16'(play_a), 16'h0);
    chk("cr_pend",   16'(pend_a), 16'h0);

    // UI re-request while playing replays; request on grant cycle merges
    step(1'b0, 4'b0001, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    play_ticks(1);
    step(1'b0, 4'b0001, 4'b0000, 1'b0);
    chk("rq_pend",   16'(pend_a), 16'h1);
    chk("rq_play",   16'(play_a), 16'h1);
    play_ticks(3);
    chk("rq_end",    16'(play_a), 16'h0);
    play_ticks(2);
    step(1'b0, 4'b0001, 4'b0000, 1'b0);
    chk("rq_replay", 16'(play_a), 16'h1);
    chk("rq_merge",  16'(pend_a), 16'h0);
    play_ticks(4);
    play_ticks(2);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("rq_noplay", 16'(play_a), 16'h0);
    chk("rq_nobusy", 16'(busy_a), 16'h0);

    // Zero-gap instance: NEXTLEVEL then UI back to back
    step(1'b0, 4'b0000, 4'b0011, 1'b0);
    chk("ng_pend",   16'(pend_b), 16'h3);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("ng_sel1",   16'(sel_b),  16'h1);
    chk("ng_play1",  16'(play_b), 16'h1);
    play_ticks(2);
    chk("ng_t2",     16'(play_b), 16'h1);
    play_ticks(1);
    chk("ng_low",    16'(play_b), 16'h0);
    chk("ng_idle",   16'(busy_b), 16'h0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("ng_sel0",   16'(sel_b),  16'h0);
    chk("ng_play2",  16'(play_b), 16'h1);

    // Reset mid-CRASH with lower requests queued
    step(1'b0, 4'b0100, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    play_ticks(2);
    step(1'b0, 4'b0011, 4'b0000, 1'b0);
    chk("mr_pend",   16'(pend_a), 16'h3);
    chk("mr_sel",    16'(sel_a),  16'h2);
    step(1'b1, 4'b0001, 4'b0000, 1'b1);
    chk("mr_play",   16'(play_a), 16'h0);
    chk("mr_pclr",   16'(pend_a), 16'h0);
    chk("mr_busy",   16'(busy_a), 16'h0);
    chk("mr_sel0",   16'(sel_a),  16'h0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("mr_stay",   16'(play_a), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
